acc_req_arbiter: RTL and testbench

ACC_REQ_ARBITER -- requirements
Module: acc_req_arbiter

---
 rtl/acc_pkg.sv | 14 +
 rtl/acc_req_arbiter_pkg.sv | 18 +
 rtl/fifo_v3.sv | 63 ++++++
 rtl/acc_req_arbiter.sv | 136 +++++++++++++
 tb/tb_acc_req_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator request/response payload types.
package acc_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] rs1;
    } accelerator_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } accelerator_resp_t;

endpackage

// File: rtl/acc_req_arbiter_pkg.sv
// Parameter limits, arbiter state encoding and index-width helper for acc_req_arbiter.
package acc_req_arbiter_pkg;

    localparam int unsigned MinNrReq         = 2;
    localparam int unsigned MaxNrReq         = 8;
    localparam int unsigned MinOutstanding   = 1;
    localparam int unsigned OutstandingLimit = 16;

    typedef enum logic {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through; usage_o wraps to 0 when a power-of-two FIFO is full.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [31:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    dtype                  mem_q [FifoDepth];
    logic                  cnt_zero, bypass, do_push, do_pop;

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign cnt_zero = (cnt_q == '0);
    assign full_o   = (cnt_q == (ADDR_DEPTH + 1)'(FifoDepth));
    assign empty_o  = cnt_zero && !(FALL_THROUGH && push_i);
    assign usage_o  = cnt_q[ADDR_DEPTH-1:0];
    assign data_o   = (FALL_THROUGH && cnt_zero) ? data_i : mem_q[rd_ptr_q];

    // In fall-through mode a push and pop on an empty FIFO pass straight through.
    assign bypass  = FALL_THROUGH && cnt_zero && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && !cnt_zero;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator port among NrReq requesters,
// routing in-order responses back to the issuing requester via an ID queue.
module acc_req_arbiter
    import acc_req_arbiter_pkg::*;
#(
    parameter int unsigned NrReq          = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         acc_req_t      = acc_pkg::accelerator_req_t,
    parameter type         acc_resp_t     = acc_pkg::accelerator_resp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic      [NrReq-1:0] req_valid_i,
    output logic      [NrReq-1:0] req_ready_o,
    input  acc_req_t  [NrReq-1:0] req_i,
    output logic                  acc_req_valid_o,
    input  logic                  acc_req_ready_i,
    output acc_req_t              acc_req_o,
    input  logic                  acc_resp_valid_i,
    output logic                  acc_resp_ready_o,
    input  acc_resp_t             acc_resp_i,
    output logic      [NrReq-1:0] resp_valid_o,
    input  logic      [NrReq-1:0] resp_ready_i,
    output acc_resp_t [NrReq-1:0] resp_o
);

    localparam int unsigned IdxW   = idx_width(NrReq);
    localparam int unsigned CntW   = idx_width(MaxOutstanding + 1);
    localparam int unsigned QAddrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    if (NrReq < MinNrReq || NrReq > MaxNrReq) begin : gen_bad_nr_req
        $fatal(1, "acc_req_arbiter: NrReq must be in 2..8");
    end
    if (MaxOutstanding < MinOutstanding || MaxOutstanding > OutstandingLimit) begin : gen_bad_outstanding
        $fatal(1, "acc_req_arbiter: MaxOutstanding must be in 1..16");
    end

    arb_state_e        state_q;
    logic [IdxW-1:0]   lock_idx_q, last_grant_q;
    logic [IdxW-1:0]   arb_idx, rr_cand, gnt_idx, head_idx;
    logic              arb_found, gnt_req;
    logic              q_full, q_empty, push, pop, resp_drop;
    logic [QAddrW-1:0] q_usage;
    logic [CntW-1:0]   occupancy;

    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        rr_cand   = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            rr_cand = IdxW'((32'(last_grant_q) + 32'd1 + i) % NrReq);
            if (!arb_found && req_valid_i[rr_cand]) begin
                arb_found = 1'b1;
                arb_idx   = rr_cand;
            end
        end
    end

    assign gnt_idx         = (state_q == ArbLocked) ? lock_idx_q : arb_idx;
    assign gnt_req         = (state_q == ArbLocked) ? req_valid_i[lock_idx_q] : arb_found;
    assign acc_req_valid_o = gnt_req && !q_full;
    assign acc_req_o       = acc_req_valid_o ? req_i[gnt_idx] : '0;
    assign push            = acc_req_valid_o && acc_req_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (acc_req_valid_o) req_ready_o[gnt_idx] = acc_req_ready_i;
    end

    // An offered-but-stalled grant is pinned until the accelerator accepts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ArbIdle;
            lock_idx_q   <= '0;
            last_grant_q <= IdxW'(NrReq - 1);
        end else begin
            case (state_q)
                ArbIdle: begin
                    if (acc_req_valid_o) begin
                        if (acc_req_ready_i) begin
                            last_grant_q <= gnt_idx;
                        end else begin
                            state_q    <= ArbLocked;
                            lock_idx_q <= gnt_idx;
                        end
                    end
                end
                ArbLocked: begin
                    if (push) begin
                        state_q      <= ArbIdle;
                        last_grant_q <= gnt_idx;
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxOutstanding),
        .dtype        (logic [IdxW-1:0])
    ) i_id_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (q_full),
        .empty_o (q_empty),
        .usage_o (q_usage),
        .data_i  (gnt_idx),
        .push_i  (push),
        .data_o  (head_idx),
        .pop_i   (pop)
    );

    assign occupancy        = q_full ? CntW'(MaxOutstanding) : CntW'(q_usage);
    assign resp_drop        = acc_resp_valid_i && q_empty;
    assign acc_resp_ready_o = q_empty ? 1'b1 : resp_ready_i[head_idx];
    assign pop              = acc_resp_valid_i && !q_empty && resp_ready_i[head_idx];

    always_comb begin
        resp_valid_o = '0;
        if (!q_empty) resp_valid_o[head_idx] = acc_resp_valid_i;
    end

    always_comb begin
        for (int unsigned i = 0; i < NrReq; i++) resp_o[i] = acc_resp_i;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !resp_drop)
        else $warning("acc_req_arbiter: response with empty ID queue dropped");

    assert property (@(posedge clk_i) disable iff (!rst_ni) occupancy <= CntW'(MaxOutstanding))
        else $error("acc_req_arbiter: occupancy exceeds MaxOutstanding");

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter with NrReq=2, MaxOutstanding=4.
module tb_acc_req_arbiter;
    import acc_pkg::*;

    localparam int unsigned NrReq  = 2;
    localparam int unsigned MaxOut = 4;

    localparam accelerator_req_t  P0 = '{insn: 32'h0000_00a0, rs1: 32'h1111_0000};
    localparam accelerator_req_t  P1 = '{insn: 32'h0000_00b1, rs1: 32'h2222_0001};
    localparam accelerator_resp_t R0 = '{data: 32'hcafe_0000, error: 1'b1};
    localparam accelerator_resp_t R1 = '{data: 32'h1234_5678, error: 1'b0};

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic              [NrReq-1:0] req_valid, req_ready, resp_valid, resp_ready;
    accelerator_req_t  [NrReq-1:0] req;
    accelerator_resp_t [NrReq-1:0] resp;
    logic                          acc_req_valid, acc_req_ready, acc_resp_valid, acc_resp_ready;
    accelerator_req_t              acc_req;
    accelerator_resp_t             acc_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_req_arbiter #(
        .NrReq          (NrReq),
        .MaxOutstanding (MaxOut),
        .acc_req_t      (accelerator_req_t),
        .acc_resp_t     (accelerator_resp_t)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_i            (req),
        .acc_req_valid_o  (acc_req_valid),
        .acc_req_ready_i  (acc_req_ready),
        .acc_req_o        (acc_req),
        .acc_resp_valid_i (acc_resp_valid),
        .acc_resp_ready_o (acc_resp_ready),
        .acc_resp_i       (acc_resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_o           (resp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req[0]         = P0;
        req[1]         = P1;
        acc_req_ready  = 1'b0;
        acc_resp_valid = 1'b0;
        acc_resp       = '0;
        resp_ready     = 2'b11;

        // Reset state
        tick(); settle();
        chk("rst_acc_req_valid", acc_req_valid, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_acc_req", acc_req, '0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_acc_resp_ready", acc_resp_ready, 1'b1);
        chk("rst_resp", resp, '0);
        chk("rst_occupancy", dut.occupancy, 0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("post_rst_acc_resp_ready", acc_resp_ready, 1'b1);

        // Both requesting, accelerator always ready: 0,1,0,1 then full
        tick();
        req_valid = 2'b11; acc_req_ready = 1'b1;
        settle();
        chk("rr_g0_valid", acc_req_valid, 1'b1);
        chk("rr_g0_req", acc_req, P0);
        chk("rr_g0_ready", req_ready, 2'b01);
        tick(); settle();
        chk("rr_g1_req", acc_req, P1);
        chk("rr_g1_ready", req_ready, 2'b10);
        tick(); settle();
        chk("rr_g2_req", acc_req, P0);
        chk("rr_g2_ready", req_ready, 2'b01);
        tick(); settle();
        chk("rr_g3_req", acc_req, P1);
        chk("rr_g3_ready", req_ready, 2'b10);
        tick(); settle();
        chk("full_acc_req_valid", acc_req_valid, 1'b0);
        chk("full_req_ready", req_ready, 2'b00);
        chk("full_occupancy", dut.occupancy, 4);

        // Full queue with a response: no grant, pop head (requester 0)
        tick();
        acc_resp_valid = 1'b1; acc_resp = R0;
        settle();
        chk("full_pop_acc_req_valid", acc_req_valid, 1'b0);
        chk("full_pop_req_ready", req_ready, 2'b00);
        chk("full_pop_resp_valid", resp_valid, 2'b01);
        chk("full_pop_acc_resp_ready", acc_resp_ready, 1'b1);
        chk("resp_lane0", resp[0], R0);
        chk("resp_lane1", resp[1], R0);
        tick();
        acc_resp_valid = 1'b0;
        settle();
        chk("after_pop_occupancy", dut.occupancy, 3);
        chk("resume_valid", acc_req_valid, 1'b1);
        chk("resume_req", acc_req, P0);
        tick();
        req_valid = 2'b00; acc_req_ready = 1'b0;

        // Drain queue 1,0,1,0 with a stall on requester 0
        acc_resp_valid = 1'b1; acc_resp = R1;
        settle();
        chk("drain_h1", resp_valid, 2'b10);
        tick(); settle();
        chk("drain_h0", resp_valid, 2'b01);
        tick(); settle();
        chk("drain_h1b", resp_valid, 2'b10);
        tick();
        resp_ready = 2'b10;
        settle();
        chk("stall_resp_valid", resp_valid, 2'b01);
        chk("stall_acc_resp_ready", acc_resp_ready, 1'b0);
        tick(); settle();
        chk("stall_occupancy", dut.occupancy, 1);
        chk("stall_hold_ready", acc_resp_ready, 1'b0);
        tick();
        resp_ready = 2'b11;
        settle();
        chk("unstall_acc_resp_ready", acc_resp_ready, 1'b1);
        tick();
        acc_resp_valid = 1'b0;
        settle();
        chk("drained_occupancy", dut.occupancy, 0);

        // Issue order 1,0,1 and matching response lanes
        tick();
        req_valid = 2'b10; acc_req_ready = 1'b1;
        settle();
        chk("issue1_ready", req_ready, 2'b10);
        chk("issue1_req", acc_req, P1);
        tick();
        req_valid = 2'b01;
        settle();
        chk("issue0_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        settle();
        chk("issue1b_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00; acc_req_ready = 1'b0; acc_resp_valid = 1'b1;
        settle();
        chk("order_resp1", resp_valid, 2'b10);
        tick(); settle();
        chk("order_resp0", resp_valid, 2'b01);
        tick(); settle();
        chk("order_resp1b", resp_valid, 2'b10);
        tick();
        acc_resp_valid = 1'b0;

        // Lock on requester 0 while stalled; requester 1 joins later
        req_valid = 2'b01;
        settle();
        chk("lock_offer_valid", acc_req_valid, 1'b1);
        chk("lock_offer_req", acc_req, P0);
        chk("lock_offer_ready", req_ready, 2'b00);
        tick();
        req_valid = 2'b11;
        settle();
        chk("lock_c1_req", acc_req, P0);
        chk("lock_c1_ready", req_ready, 2'b00);
        tick(); settle();
        chk("lock_c2_req", acc_req, P0);
        tick();
        acc_req_ready = 1'b1;
        settle();
        chk("lock_accept_req", acc_req, P0);
        chk("lock_accept_ready", req_ready, 2'b01);
        tick(); settle();
        chk("lock_next_req", acc_req, P1);
        chk("lock_next_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00; acc_req_ready = 1'b0;
        settle();
        chk("pre_reset_occupancy", dut.occupancy, 2);

        // Reset with two outstanding, then a response into an empty queue
        tick();
        rst_n = 1'b0;
        settle();
        chk("midrst_occupancy", dut.occupancy, 0);
        chk("midrst_acc_resp_ready", acc_resp_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        acc_resp_valid = 1'b1; acc_resp = R1;
        settle();
        chk("drop_resp_valid", resp_valid, 2'b00);
        chk("drop_acc_resp_ready", acc_resp_ready, 1'b1);
        chk("drop_flag", dut.resp_drop, 1'b1);
        tick();
        acc_resp_valid = 1'b0;
        settle();
        chk("drop_occupancy", dut.occupancy, 0);
        chk("drop_flag_clear", dut.resp_drop, 1'b0);

        // Lock must override round-robin: last_grant=0 would otherwise favour 1
        tick();
        req_valid = 2'b01; acc_req_ready = 1'b1;
        settle();
        chk("rr_reset_first", req_ready, 2'b01);
        tick();
        acc_req_ready = 1'b0;
        settle();
        chk("lock2_offer_req", acc_req, P0);
        tick();
        req_valid = 2'b11;
        settle();
        chk("lock2_hold_req", acc_req, P0);
        chk("lock2_hold_ready", req_ready, 2'b00);
        tick();
        acc_req_ready = 1'b1;
        settle();
        chk("lock2_accept_ready", req_ready, 2'b01);
        tick(); settle();
        chk("lock2_rr_next", acc_req, P1);
        chk("lock2_rr_ready", req_ready, 2'b10);
        chk("lock2_occupancy", dut.occupancy, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
